axil_pmod_regs: RTL and testbench

AXIL_PMOD_REGS -- requirements
Module: axil_pmod_regs

---
 rtl/axil_pmod_regs.sv | 205 ++++++++++++++++++++
 tb/tb_axil_pmod_regs.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_pmod_regs.sv
// AXI4-Lite register block exposing an ID, a scratch word, cycle counter and two Pmod port pairs.
// Write and read channels run as independent FSMs; one write and one read may be outstanding.
module axil_pmod_regs #(
    parameter logic [31:0] ID_VALUE   = 32'hA7C0_0001,
    parameter int          ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic [7:0]            ja,
    input  logic [7:0]            jb,
    output logic [7:0]            jc,
    output logic [7:0]            jd
);

    localparam int IW = ADDR_WIDTH - 2;

    localparam logic [IW-1:0] IDX_ID       = IW'(0);
    localparam logic [IW-1:0] IDX_SCRATCH  = IW'(1);
    localparam logic [IW-1:0] IDX_PMOD_OUT = IW'(2);
    localparam logic [IW-1:0] IDX_PMOD_IN  = IW'(3);
    localparam logic [IW-1:0] IDX_CYCLES   = IW'(4);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_COMMIT,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    wstate_t w_state;
    rstate_t r_state;

    logic [31:0]   scratch;
    logic [15:0]   pmod_out;
    logic [31:0]   cycles;
    logic [7:0]    ja_meta, ja_s, jb_meta, jb_s;
    logic [IW-1:0] aw_idx;
    logic [31:0]   w_data;
    logic [3:0]    w_strb;

    logic          aw_hs, w_hs, ar_hs;
    logic [IW-1:0] ar_idx;
    logic [31:0]   rd_word;
    logic [1:0]    rd_resp;
    logic [31:0]   scratch_merged;
    logic          unused_addr_bits;

    // Ready signals decode the FSM state so they rise on the first cycle out of reset.
    assign s_axi_awready = !rst && (w_state == W_IDLE || w_state == W_HAVE_W);
    assign s_axi_wready  = !rst && (w_state == W_IDLE || w_state == W_HAVE_AW);
    assign s_axi_arready = !rst && (r_state == R_IDLE);

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign ar_idx = s_axi_araddr[ADDR_WIDTH-1:2];

    assign jc = pmod_out[7:0];
    assign jd = pmod_out[15:8];

    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_comb begin
        scratch_merged = scratch;
        for (int b = 0; b < 4; b++) begin
            if (w_strb[b]) scratch_merged[8*b +: 8] = w_data[8*b +: 8];
        end
    end

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        case (ar_idx)
            IDX_ID:       rd_word = ID_VALUE;
            IDX_SCRATCH:  rd_word = scratch;
            IDX_PMOD_OUT: rd_word = {16'h0000, pmod_out};
            IDX_PMOD_IN:  rd_word = {16'h0000, jb_s, ja_s};
            IDX_CYCLES:   rd_word = cycles;
            default:      rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            ja_meta <= '0;
            ja_s    <= '0;
            jb_meta <= '0;
            jb_s    <= '0;
            cycles  <= '0;
        end else begin
            ja_meta <= ja;
            ja_s    <= ja_meta;
            jb_meta <= jb;
            jb_s    <= jb_meta;
            cycles  <= cycles + 32'd1;
        end
    end

    // Write FSM; register updates happen only on leaving COMMIT, together with bvalid.
    always_ff @(posedge clock) begin
        if (rst) begin
            w_state      <= W_IDLE;
            aw_idx       <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            scratch      <= '0;
            pmod_out     <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
        end else begin
            if (aw_hs) aw_idx <= s_axi_awaddr[ADDR_WIDTH-1:2];
            if (w_hs) begin
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            case (w_state)
                W_IDLE: begin
                    if (aw_hs && w_hs) w_state <= W_COMMIT;
                    else if (aw_hs)    w_state <= W_HAVE_AW;
                    else if (w_hs)     w_state <= W_HAVE_W;
                end
                W_HAVE_AW: if (w_hs) w_state <= W_COMMIT;
                W_HAVE_W:  if (aw_hs) w_state <= W_COMMIT;
                W_COMMIT: begin
                    case (aw_idx)
                        IDX_SCRATCH: begin
                            scratch     <= scratch_merged;
                            s_axi_bresp <= RESP_OKAY;
                        end
                        IDX_PMOD_OUT: begin
                            pmod_out    <= {w_strb[1] ? w_data[15:8] : pmod_out[15:8],
                                            w_strb[0] ? w_data[7:0]  : pmod_out[7:0]};
                            s_axi_bresp <= RESP_OKAY;
                        end
                        default: s_axi_bresp <= RESP_SLVERR;
                    endcase
                    s_axi_bvalid <= 1'b1;
                    w_state      <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        w_state      <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM; data is captured at the AR handshake, so a concurrent commit is not yet visible.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state      <= R_IDLE;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        s_axi_rdata  <= rd_word;
                        s_axi_rresp  <= rd_resp;
                        s_axi_rvalid <= 1'b1;
                        r_state      <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        r_state      <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_pmod_regs.sv
// Scoreboard bench for axil_pmod_regs: expected responses are queued when a
// transaction is issued and popped when the DUT answers.
module tb_axil_pmod_regs;

    localparam logic [31:0] ID_VALUE = 32'hA7C0_0001;
    localparam logic [1:0]  OKAY     = 2'b00;
    localparam logic [1:0]  SLVERR   = 2'b10;

    logic        clock = 1'b0;
    logic        rst;
    logic [7:0]  s_axi_awaddr;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid, s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [7:0]  s_axi_araddr;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid, s_axi_rready;
    logic [7:0]  ja, jb, jc, jd;

    int vectors = 0;
    int miscompares = 0;
    int cyc_count = 0;
    int last_ar_cyc = 0;

    logic [31:0] model_scratch;
    logic [15:0] model_pmod;
    logic [33:0] rd_q[$];
    logic [1:0]  b_q[$];

    axil_pmod_regs #(.ID_VALUE(ID_VALUE), .ADDR_WIDTH(8)) dut (
        .clock(clock), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .ja(ja), .jb(jb), .jc(jc), .jd(jd)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc_count <= cyc_count + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, output logic [1:0] resp, output bit tmo);
        bit aw_done, w_done, aw_ok, w_ok;
        int n;
        tmo = 0; resp = 2'bxx; aw_done = 0; w_done = 0; n = 0;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 40) begin
            if (n == w_lead) s_axi_awvalid = 1'b1;
            aw_ok = s_axi_awvalid && s_axi_awready;
            w_ok  = s_axi_wvalid && s_axi_wready;
            @(posedge clock); #1; n++;
            if (aw_ok) begin s_axi_awvalid = 1'b0; aw_done = 1; end
            if (w_ok)  begin s_axi_wvalid = 1'b0; w_done = 1; end
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        if (!(aw_done && w_done)) begin tmo = 1; return; end
        n = 0;
        while (!s_axi_bvalid && n < 20) begin @(posedge clock); #1; n++; end
        if (!s_axi_bvalid) begin tmo = 1; return; end
        resp = s_axi_bresp;
        s_axi_bready = 1'b1;
        @(posedge clock); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output int lat, output bit tmo);
        bit acc;
        int n;
        tmo = 0; lat = 1; acc = 0; n = 0; data = 'x; resp = 2'bxx;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        while (!acc && n < 20) begin
            acc = s_axi_arready;
            @(posedge clock); #1; n++;
        end
        s_axi_arvalid = 1'b0;
        if (!acc) begin tmo = 1; return; end
        last_ar_cyc = cyc_count;
        while (!s_axi_rvalid && lat < 20) begin @(posedge clock); #1; lat++; end
        if (!s_axi_rvalid) begin tmo = 1; return; end
        data = s_axi_rdata; resp = s_axi_rresp;
        s_axi_rready = 1'b1;
        @(posedge clock); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        vectors++; if (s_axi_awready !== 1'b0) begin miscompares++; $display("FAIL reset_awready: got %b expected 0", s_axi_awready); end
        vectors++; if (s_axi_wready !== 1'b0) begin miscompares++; $display("FAIL reset_wready: got %b expected 0", s_axi_wready); end
        vectors++; if (s_axi_arready !== 1'b0) begin miscompares++; $display("FAIL reset_arready: got %b expected 0", s_axi_arready); end
        vectors++; if (s_axi_bvalid !== 1'b0) begin miscompares++; $display("FAIL reset_bvalid: got %b expected 0", s_axi_bvalid); end
        vectors++; if (s_axi_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid: got %b expected 0", s_axi_rvalid); end
        vectors++; if (s_axi_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 0", s_axi_rdata); end
        vectors++; if ({s_axi_bresp, s_axi_rresp} !== 4'h0) begin miscompares++; $display("FAIL reset_resp: got %b expected 0000", {s_axi_bresp, s_axi_rresp}); end
        vectors++; if ({jd, jc} !== 16'h0) begin miscompares++; $display("FAIL reset_pmod_out: got %h expected 0000", {jd, jc}); end
        rst = 1'b0;
        model_scratch = '0; model_pmod = '0;
        @(posedge clock); #1;
        vectors++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin miscompares++; $display("FAIL post_reset_ready: got %b expected 111", {s_axi_awready, s_axi_wready, s_axi_arready}); end
    endtask

    task automatic test_id_read();
        logic [31:0] d; logic [1:0] r; int lat; bit tmo; logic [33:0] e;
        rd_q.push_back({OKAY, ID_VALUE});
        do_read(8'h00, d, r, lat, tmo);
        e = rd_q.pop_front();
        vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL id_timeout: got %b expected 0", tmo); end
        vectors++; if ({r, d} !== e) begin miscompares++; $display("FAIL id_read: got %h expected %h", {r, d}, e); end
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL id_latency: got %0d expected 1", lat); end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d; logic [1:0] r; int lat; bit tmo; logic [1:0] eb; logic [33:0] e;
        b_q.push_back(OKAY);
        do_write(8'h04, 32'hDEADBEEF, 4'hF, 3, r, tmo);
        model_scratch = merge(model_scratch, 32'hDEADBEEF, 4'hF);
        eb = b_q.pop_front();
        vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL w_first_timeout: got %b expected 0", tmo); end
        vectors++; if (r !== eb) begin miscompares++; $display("FAIL w_first_bresp: got %b expected %b", r, eb); end
        repeat (3) @(posedge clock);
        #1;
        vectors++; if (s_axi_bvalid !== 1'b0) begin miscompares++; $display("FAIL w_first_single_b: got %b expected 0", s_axi_bvalid); end
        rd_q.push_back({OKAY, model_scratch});
        do_read(8'h04, d, r, lat, tmo);
        e = rd_q.pop_front();
        vectors++; if ({tmo, r, d} !== {1'b0, e}) begin miscompares++; $display("FAIL w_first_readback: got %h expected %h", {tmo, r, d}, {1'b0, e}); end
    endtask

    task automatic test_pmod_out();
        logic [31:0] d; logic [1:0] r; int lat; bit tmo; logic [1:0] eb; logic [33:0] e;
        b_q.push_back(OKAY);
        do_write(8'h08, 32'h0000A55A, 4'b0001, 0, r, tmo);
        model_pmod = merge({16'h0, model_pmod}, 32'h0000A55A, 4'b0001);
        eb = b_q.pop_front();
        vectors++; if ({tmo, r} !== {1'b0, eb}) begin miscompares++; $display("FAIL pmod_lane0_bresp: got %b expected %b", {tmo, r}, {1'b0, eb}); end
        vectors++; if ({jd, jc} !== model_pmod) begin miscompares++; $display("FAIL pmod_lane0_pins: got %h expected %h", {jd, jc}, model_pmod); end
        b_q.push_back(OKAY);
        do_write(8'h08, 32'hFFFFFFFF, 4'hF, 0, r, tmo);
        model_pmod = merge({16'h0, model_pmod}, 32'hFFFFFFFF, 4'hF);
        eb = b_q.pop_front();
        vectors++; if ({tmo, r} !== {1'b0, eb}) begin miscompares++; $display("FAIL pmod_full_bresp: got %b expected %b", {tmo, r}, {1'b0, eb}); end
        b_q.push_back(OKAY);
        do_write(8'h08, 32'h00001234, 4'h0, 0, r, tmo);
        eb = b_q.pop_front();
        vectors++; if ({tmo, r} !== {1'b0, eb}) begin miscompares++; $display("FAIL pmod_nostrb_bresp: got %b expected %b", {tmo, r}, {1'b0, eb}); end
        vectors++; if ({jd, jc} !== model_pmod) begin miscompares++; $display("FAIL pmod_full_pins: got %h expected %h", {jd, jc}, model_pmod); end
        rd_q.push_back({OKAY, 16'h0, model_pmod});
        do_read(8'h08, d, r, lat, tmo);
        e = rd_q.pop_front();
        vectors++; if ({tmo, r, d} !== {1'b0, e}) begin miscompares++; $display("FAIL pmod_readback: got %h expected %h", {tmo, r, d}, {1'b0, e}); end
    endtask

    task automatic test_pmod_in_and_errors();
        logic [31:0] d; logic [1:0] r; int lat; bit tmo; logic [1:0] eb; logic [33:0] e;
        logic [7:0] waddrs[3];
        waddrs = '{8'h0C, 8'h20, 8'h00};
        ja = 8'h3C; jb = 8'hC3;
        repeat (3) @(posedge clock);
        #1;
        rd_q.push_back({OKAY, 16'h0, jb, ja});
        do_read(8'h0C, d, r, lat, tmo);
        e = rd_q.pop_front();
        vectors++; if ({tmo, r, d} !== {1'b0, e}) begin miscompares++; $display("FAIL pmod_in: got %h expected %h", {tmo, r, d}, {1'b0, e}); end
        rd_q.push_back({OKAY, 16'h0, jb, ja});
        do_read(8'h0F, d, r, lat, tmo);
        e = rd_q.pop_front();
        vectors++; if ({tmo, r, d} !== {1'b0, e}) begin miscompares++; $display("FAIL pmod_in_lowbits: got %h expected %h", {tmo, r, d}, {1'b0, e}); end
        foreach (waddrs[i]) begin
            b_q.push_back(SLVERR);
            do_write(waddrs[i], 32'h5555AAAA, 4'hF, 0, r, tmo);
            eb = b_q.pop_front();
            vectors++; if ({tmo, r} !== {1'b0, eb}) begin miscompares++; $display("FAIL ro_write_%h: got %b expected %b", waddrs[i], {tmo, r}, {1'b0, eb}); end
        end
        rd_q.push_back({SLVERR, 32'h0});
        do_read(8'h20, d, r, lat, tmo);
        e = rd_q.pop_front();
        vectors++; if ({tmo, r, d} !== {1'b0, e}) begin miscompares++; $display("FAIL unmapped_read: got %h expected %h", {tmo, r, d}, {1'b0, e}); end
        rd_q.push_back({OKAY, ID_VALUE});
        do_read(8'h00, d, r, lat, tmo);
        e = rd_q.pop_front();
        vectors++; if ({tmo, r, d} !== {1'b0, e}) begin miscompares++; $display("FAIL id_after_write: got %h expected %h", {tmo, r, d}, {1'b0, e}); end
        rd_q.push_back({OKAY, model_scratch});
        do_read(8'h04, d, r, lat, tmo);
        e = rd_q.pop_front();
        vectors++; if ({tmo, r, d} !== {1'b0, e}) begin miscompares++; $display("FAIL scratch_after_errors: got %h expected %h", {tmo, r, d}, {1'b0, e}); end
    endtask

    task automatic test_scratch_strobes();
        logic [31:0] d, wd; logic [1:0] r; int lat; bit tmo; logic [3:0] st; logic [1:0] eb; logic [33:0] e;
        for (int i = 0; i < 8; i++) begin
            wd = $urandom;
            st = 4'($urandom_range(0, 15));
            b_q.push_back(OKAY);
            do_write(8'h04, wd, st, i % 3, r, tmo);
            model_scratch = merge(model_scratch, wd, st);
            eb = b_q.pop_front();
            vectors++; if ({tmo, r} !== {1'b0, eb}) begin miscompares++; $display("FAIL strobe_bresp_%0d: got %b expected %b", i, {tmo, r}, {1'b0, eb}); end
            rd_q.push_back({OKAY, model_scratch});
            do_read(8'h04, d, r, lat, tmo);
            e = rd_q.pop_front();
            vectors++; if ({tmo, r, d} !== {1'b0, e}) begin miscompares++; $display("FAIL strobe_read_%0d: got %h expected %h", i, {tmo, r, d}, {1'b0, e}); end
        end
    endtask

    task automatic test_cycles();
        logic [31:0] d1, d2; logic [1:0] r1, r2; int lat, c1; bit t1, t2;
        do_read(8'h10, d1, r1, lat, t1);
        c1 = last_ar_cyc;
        repeat (5) @(posedge clock);
        #1;
        do_read(8'h10, d2, r2, lat, t2);
        vectors++; if ({t1, t2, r1, r2} !== 6'b0) begin miscompares++; $display("FAIL cycles_resp: got %b expected 000000", {t1, t2, r1, r2}); end
        vectors++; if ((d2 - d1) !== 32'(last_ar_cyc - c1)) begin miscompares++; $display("FAIL cycles_delta: got %0d expected %0d", d2 - d1, last_ar_cyc - c1); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d, old; logic [1:0] r; int lat; bit tmo; logic [33:0] e;
        old = model_scratch;
        s_axi_awaddr = 8'h04; s_axi_wdata = 32'h600DF00D; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        rd_q.push_back({OKAY, old});
        @(posedge clock); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_araddr = 8'h04; s_axi_arvalid = 1'b1;
        @(posedge clock); #1;
        s_axi_arvalid = 1'b0;
        model_scratch = 32'h600DF00D;
        e = rd_q.pop_front();
        vectors++; if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, e}) begin miscompares++; $display("FAIL same_cycle_read: got %h expected %h", {s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {1'b1, e}); end
        vectors++; if ({s_axi_bvalid, s_axi_bresp} !== {1'b1, OKAY}) begin miscompares++; $display("FAIL same_cycle_b: got %b expected 100", {s_axi_bvalid, s_axi_bresp}); end
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        @(posedge clock); #1;
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        rd_q.push_back({OKAY, model_scratch});
        do_read(8'h04, d, r, lat, tmo);
        e = rd_q.pop_front();
        vectors++; if ({tmo, r, d} !== {1'b0, e}) begin miscompares++; $display("FAIL same_cycle_after: got %h expected %h", {tmo, r, d}, {1'b0, e}); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic [1:0] r; int lat; bit tmo; logic [33:0] e;
        s_axi_awaddr = 8'h04; s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'hF;
        s_axi_araddr = 8'h00;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        @(posedge clock); #1;
        s_axi_awaddr = 8'h04; s_axi_wdata = 32'h0BAD0BAD; s_axi_araddr = 8'h08;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            vectors++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin miscompares++; $display("FAIL bp_ready_%0d: got %b expected 000", i, {s_axi_awready, s_axi_wready, s_axi_arready}); end
            vectors++; if ({s_axi_bvalid, s_axi_bresp} !== {1'b1, OKAY}) begin miscompares++; $display("FAIL bp_b_%0d: got %b expected 100", i, {s_axi_bvalid, s_axi_bresp}); end
            vectors++; if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, OKAY, ID_VALUE}) begin miscompares++; $display("FAIL bp_r_%0d: got %h expected %h", i, {s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {1'b1, OKAY, ID_VALUE}); end
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        @(posedge clock); #1;
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        model_scratch = 32'hCAFEF00D;
        vectors++; if ({s_axi_bvalid, s_axi_rvalid} !== 2'b00) begin miscompares++; $display("FAIL bp_release: got %b expected 00", {s_axi_bvalid, s_axi_rvalid}); end
        rd_q.push_back({OKAY, model_scratch});
        do_read(8'h04, d, r, lat, tmo);
        e = rd_q.pop_front();
        vectors++; if ({tmo, r, d} !== {1'b0, e}) begin miscompares++; $display("FAIL bp_no_second_write: got %h expected %h", {tmo, r, d}, {1'b0, e}); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r; int lat, n; bit tmo; logic [33:0] e;
        s_axi_awaddr = 8'h04; s_axi_awvalid = 1'b1;
        @(posedge clock); #1;
        s_axi_awvalid = 1'b0;
        vectors++; if ({s_axi_awready, s_axi_wready} !== 2'b01) begin miscompares++; $display("FAIL have_aw_ready: got %b expected 01", {s_axi_awready, s_axi_wready}); end
        rst = 1'b1;
        @(posedge clock); #1;
        vectors++; if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid} !== 4'b0000) begin miscompares++; $display("FAIL mid_reset_outputs: got %b expected 0000", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid}); end
        @(posedge clock); #1;
        rst = 1'b0;
        model_scratch = '0; model_pmod = '0;
        vectors++; if ({jd, jc} !== model_pmod) begin miscompares++; $display("FAIL mid_reset_pins: got %h expected %h", {jd, jc}, model_pmod); end
        s_axi_wdata = 32'h00000055; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(posedge clock); #1;
        s_axi_wvalid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        vectors++; if (s_axi_bvalid !== 1'b0) begin miscompares++; $display("FAIL stale_aw_bvalid: got %b expected 0", s_axi_bvalid); end
        s_axi_awaddr = 8'h04; s_axi_awvalid = 1'b1;
        @(posedge clock); #1;
        s_axi_awvalid = 1'b0;
        b_q.push_back(OKAY);
        n = 0;
        while (!s_axi_bvalid && n < 20) begin @(posedge clock); #1; n++; end
        vectors++; if ({s_axi_bvalid, s_axi_bresp} !== {1'b1, b_q.pop_front()}) begin miscompares++; $display("FAIL post_reset_write: got %b expected 100", {s_axi_bvalid, s_axi_bresp}); end
        s_axi_bready = 1'b1;
        @(posedge clock); #1;
        s_axi_bready = 1'b0;
        model_scratch = 32'h00000055;
        rd_q.push_back({OKAY, model_scratch});
        do_read(8'h04, d, r, lat, tmo);
        e = rd_q.pop_front();
        vectors++; if ({tmo, r, d} !== {1'b0, e}) begin miscompares++; $display("FAIL post_reset_read: got %h expected %h", {tmo, r, d}, {1'b0, e}); end
    endtask

    initial begin
        rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        ja = '0; jb = '0;
        model_scratch = '0; model_pmod = '0;
        test_reset();
        test_id_read();
        test_w_before_aw();
        test_pmod_out();
        test_pmod_in_and_errors();
        test_scratch_strobes();
        test_cycles();
        test_same_cycle();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
